// File: rtl/fixed_point_mult_pipe_if.sv
// Stream interface for the pipelined sign-magnitude multiplier.
// Carries the operand side (in_*) and the product side (out_*) of the
// valid/ready handshake. Lanes are packed side by side, lane i at [i*WIDTH +: WIDTH].
interface fixed_point_mult_pipe_if #(
   parameter int WIDTH = 16,
   parameter int LANES = 1
);
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*WIDTH-1:0]   in_a;
   logic [LANES*WIDTH-1:0]   in_b;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*WIDTH-1:0]   out_p;
   logic [LANES-1:0]         out_ovf;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p, out_ovf
   );
endinterface

// File: rtl/fixed_point_mult_pipe.sv
// Three-stage, multi-lane sign-magnitude fixed-point multiplier for the FFT datapath.
// S1 registers the operands, S2 forms sign and full-width magnitude product,
// S3 rounds, scales by 2^-FRAC, saturates or wraps, and drives the result.
// Every stage has its own load enable so bubbles collapse under backpressure.
// A saturating 16-bit counter tallies output transfers that carry any overflow.
module fixed_point_mult_pipe #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int LANES = 1,
   parameter int ROUND = 1,
   parameter int SAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   fixed_point_mult_pipe_if.slave  bus,
   input  logic                    ovf_clr,
   output logic [15:0]             ovf_count
);

   localparam int MW = WIDTH - 1;
   localparam int PW = 2 * MW;
   localparam int BW = LANES * WIDTH;

   localparam logic [PW:0] C_HALF      = (PW+1)'(1) << (FRAC - 1);
   localparam logic [PW:0] C_ROUND_ADD = (ROUND != 0) ? C_HALF : '0;
   localparam logic [PW:0] C_MAXMAG    = (PW+1)'({MW{1'b1}});

   logic                       r_s1Valid;
   logic [BW-1:0]              r_s1A;
   logic [BW-1:0]              r_s1B;

   logic                       r_s2Valid;
   logic [LANES-1:0]           r_s2Sign;
   logic [LANES-1:0][PW-1:0]   r_s2Mag;

   logic                       r_s3Valid;
   logic [BW-1:0]              r_outP;
   logic [LANES-1:0]           r_outOvf;

   logic [15:0]                r_ovfCount;

   logic                       w_load1;
   logic                       w_load2;
   logic                       w_load3;
   logic [LANES-1:0][PW:0]     w_rounded;
   logic [LANES-1:0][PW:0]     w_shifted;
   logic [LANES-1:0][MW-1:0]   w_laneMag;
   logic [BW-1:0]              w_nextP;
   logic [LANES-1:0]           w_nextOvf;

   // Stage load enables: a stage takes new data when empty or when its successor moves on.
   always_comb begin
      w_load3 = !r_s3Valid || bus.out_ready;
      w_load2 = !r_s2Valid || w_load3;
      w_load1 = !r_s1Valid || w_load2;
   end

   assign bus.in_ready  = w_load1;
   assign bus.out_valid = r_s3Valid;
   assign bus.out_p     = r_outP;
   assign bus.out_ovf   = r_outOvf;
   assign ovf_count     = r_ovfCount;

   // S1 valid bit; reset flushes whatever was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
      end else if (w_load1) begin
         r_s1Valid <= bus.in_valid;
      end
   end

   // S1 operand capture; only real transfers overwrite the registers.
   always_ff @(posedge clk) begin
      if (w_load1 && bus.in_valid) begin
         r_s1A <= bus.in_a;
         r_s1B <= bus.in_b;
      end
   end

   // S2 valid bit follows S1 whenever S2 is allowed to load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2Valid <= 1'b0;
      end else if (w_load2) begin
         r_s2Valid <= r_s1Valid;
      end
   end

   // S2 per-lane sign and full-precision magnitude product.
   always_ff @(posedge clk) begin
      if (w_load2 && r_s1Valid) begin
         for (int i = 0; i < LANES; i++) begin
            r_s2Sign[i] <= r_s1A[i*WIDTH + MW] ^ r_s1B[i*WIDTH + MW];
            r_s2Mag[i]  <= PW'(r_s1A[i*WIDTH +: MW]) * PW'(r_s1B[i*WIDTH +: MW]);
         end
      end
   end

   // S3 arithmetic: round, drop FRAC bits, detect overflow, clamp or wrap, kill negative zero.
   always_comb begin
      w_rounded = '0;
      w_shifted = '0;
      w_laneMag = '0;
      w_nextP   = '0;
      w_nextOvf = '0;
      for (int i = 0; i < LANES; i++) begin
         w_rounded[i] = {1'b0, r_s2Mag[i]} + C_ROUND_ADD;
         w_shifted[i] = w_rounded[i] >> FRAC;
         w_nextOvf[i] = (w_shifted[i] > C_MAXMAG);
         w_laneMag[i] = ((SAT != 0) && w_nextOvf[i]) ? {MW{1'b1}} : w_shifted[i][MW-1:0];
         w_nextP[i*WIDTH +: WIDTH] = {r_s2Sign[i] && (w_laneMag[i] != '0), w_laneMag[i]};
      end
   end

   // S3 output register; holds its contents while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s3Valid <= 1'b0;
         r_outP    <= '0;
         r_outOvf  <= '0;
      end else if (w_load3) begin
         r_s3Valid <= r_s2Valid;
         if (r_s2Valid) begin
            r_outP   <= w_nextP;
            r_outOvf <= w_nextOvf;
         end
      end
   end

   // Saturating overflow tally; a clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || ovf_clr) begin
         r_ovfCount <= '0;
      end else if (r_s3Valid && bus.out_ready && (|r_outOvf) && (r_ovfCount != 16'hFFFF)) begin
         r_ovfCount <= r_ovfCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_fixed_point_mult_pipe.sv
// Bench for fixed_point_mult_pipe: two instances share stimulus and flow control,
// A with ROUND=1/SAT=1 and B with ROUND=0/SAT=0, each with its own scoreboard queue
// and overflow-counter model. Inputs change 1 time unit after a rising edge and all
// observation happens on the falling edge.
module tb_fixed_point_mult_pipe;

   typedef struct {
      logic [31:0] p;
      logic [1:0]  ovf;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] pA;
      logic        ovfA;
      logic [15:0] pB;
      logic        ovfB;
   } vec_t;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        inValid  = 1'b0;
   logic        outReady = 1'b1;
   logic        ovfClr   = 1'b0;
   logic [31:0] inA      = '0;
   logic [31:0] inB      = '0;
   logic [15:0] ovfCountA;
   logic [15:0] ovfCountB;

   int          testsRun    = 0;
   int          testsFailed = 0;

   res_t        qA[$];
   res_t        qB[$];
   res_t        drvExpA;
   res_t        drvExpB;
   logic [15:0] expCntA = '0;
   logic [15:0] expCntB = '0;
   logic        incA;
   logic        incB;
   vec_t        vecs[14];

   always #5 clk = ~clk;

   fixed_point_mult_pipe_if #(.WIDTH(16), .LANES(2)) busA ();
   fixed_point_mult_pipe_if #(.WIDTH(16), .LANES(2)) busB ();

   assign busA.in_valid  = inValid;
   assign busA.in_a      = inA;
   assign busA.in_b      = inB;
   assign busA.out_ready = outReady;
   assign busB.in_valid  = inValid;
   assign busB.in_a      = inA;
   assign busB.in_b      = inB;
   assign busB.out_ready = outReady;

   fixed_point_mult_pipe #(.WIDTH(16), .FRAC(8), .LANES(2), .ROUND(1), .SAT(1)) dutA (
      .clk       (clk),
      .rst       (rst),
      .bus       (busA.slave),
      .ovf_clr   (ovfClr),
      .ovf_count (ovfCountA)
   );

   fixed_point_mult_pipe #(.WIDTH(16), .FRAC(8), .LANES(2), .ROUND(0), .SAT(0)) dutB (
      .clk       (clk),
      .rst       (rst),
      .bus       (busB.slave),
      .ovf_clr   (ovfClr),
      .ovf_count (ovfCountB)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
      end
   endtask

   // Reference arithmetic for one lane, straight from the number format definition.
   function automatic void mulModel(input logic [15:0] a, input logic [15:0] b, input bit round,
                                    input bit sat, output logic [15:0] p, output logic ovf);
      logic [30:0] ma;
      logic [30:0] mb;
      logic [30:0] r;
      logic [30:0] sh;
      logic [14:0] mag;
      ma  = {16'b0, a[14:0]};
      mb  = {16'b0, b[14:0]};
      r   = ma * mb + (round ? 31'd128 : 31'd0);
      sh  = r >> 8;
      ovf = (sh > 31'h7FFF);
      mag = (ovf && sat) ? 15'h7FFF : sh[14:0];
      p   = {(a[15] ^ b[15]) && (mag != 15'd0), mag};
   endfunction

   function automatic res_t modelSet(input logic [31:0] a, input logic [31:0] b, input bit round, input bit sat);
      res_t        r;
      logic [15:0] p;
      logic        o;
      r.p   = '0;
      r.ovf = '0;
      for (int i = 0; i < 2; i++) begin
         mulModel(a[i*16 +: 16], b[i*16 +: 16], round, sat, p, o);
         r.p[i*16 +: 16] = p;
         r.ovf[i]        = o;
      end
      return r;
   endfunction

   task automatic setOperands(input logic [31:0] a, input logic [31:0] b);
      inA     = a;
      inB     = b;
      drvExpA = modelSet(a, b, 1'b1, 1'b1);
      drvExpB = modelSet(a, b, 1'b0, 1'b0);
   endtask

   // Present one operand set and hold it until accepted; returns 1 unit after the accepting edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input res_t expA, input res_t expB);
      bit accepted;
      inA      = a;
      inB      = b;
      drvExpA  = expA;
      drvExpB  = expB;
      inValid  = 1'b1;
      accepted = 1'b0;
      for (int n = 0; n < 500 && !accepted; n++) begin
         @(negedge clk);
         accepted = busA.in_ready;
      end
      if (!accepted) checkOutput("acceptTimeout", 32'(busA.in_ready), 32'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic waitDrain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         done = (qA.size() == 0) && (qB.size() == 0);
      end
      if (!done) checkOutput("drainTimeout", 32'(qA.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard and counter model: observe handshakes on the falling edge.
   always @(negedge clk) begin
      incA = 1'b0;
      incB = 1'b0;
      if (rst) begin
         qA.delete();
         qB.delete();
         expCntA = '0;
         expCntB = '0;
      end else begin
         checkOutput("ovfCountA", 32'(ovfCountA), 32'(expCntA));
         checkOutput("ovfCountB", 32'(ovfCountB), 32'(expCntB));
         if (busA.out_valid) begin
            if (qA.size() == 0) begin
               checkOutput("unexpectedOutA", 32'(busA.out_valid), 32'd0);
            end else begin
               checkOutput("outPA", busA.out_p, qA[0].p);
               checkOutput("outOvfA", 32'(busA.out_ovf), 32'(qA[0].ovf));
               if (outReady) begin
                  incA = |qA[0].ovf;
                  void'(qA.pop_front());
               end
            end
         end
         if (busB.out_valid) begin
            if (qB.size() == 0) begin
               checkOutput("unexpectedOutB", 32'(busB.out_valid), 32'd0);
            end else begin
               checkOutput("outPB", busB.out_p, qB[0].p);
               checkOutput("outOvfB", 32'(busB.out_ovf), 32'(qB[0].ovf));
               if (outReady) begin
                  incB = |qB[0].ovf;
                  void'(qB.pop_front());
               end
            end
         end
         if (ovfClr) expCntA = '0;
         else if (incA && expCntA != 16'hFFFF) expCntA = expCntA + 16'd1;
         if (ovfClr) expCntB = '0;
         else if (incB && expCntB != 16'hFFFF) expCntB = expCntB + 16'd1;
         if (inValid && busA.in_ready) qA.push_back(drvExpA);
         if (inValid && busB.in_ready) qB.push_back(drvExpB);
      end
   end

   // Hard stop if something wedges beyond every per-wait bound.
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time exceeded, %0d tests run", testsRun);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      res_t   eA;
      res_t   eB;
      res_t   ovfResA;
      res_t   ovfResB;
      logic [31:0] a;
      logic [31:0] b;
      int     j;
      int     n;
      int     sent;
      bit     acc;

      //            a         b         pA     ovfA  pB     ovfB
      vecs[0]  = '{16'h0180, 16'h8200, 16'h8300, 1'b0, 16'h8300, 1'b0};
      vecs[1]  = '{16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0100, 1'b0};
      vecs[2]  = '{16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 16'h7E00, 1'b1};
      vecs[3]  = '{16'h0001, 16'h0080, 16'h0001, 1'b0, 16'h0000, 1'b0};
      vecs[4]  = '{16'h8001, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[5]  = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[6]  = '{16'hFFFF, 16'h0100, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
      vecs[7]  = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 1'b1, 16'h7F00, 1'b1};
      vecs[8]  = '{16'h0080, 16'h8001, 16'h8001, 1'b0, 16'h0000, 1'b0};
      vecs[9]  = '{16'h0180, 16'h0180, 16'h0240, 1'b0, 16'h0240, 1'b0};
      vecs[10] = '{16'h8100, 16'h00FF, 16'h80FF, 1'b0, 16'h80FF, 1'b0};
      vecs[11] = '{16'h0001, 16'h007F, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[12] = '{16'hC000, 16'h0200, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
      vecs[13] = '{16'h5555, 16'h0180, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0};

      ovfResA.p = 32'h7FFF7FFF; ovfResA.ovf = 2'b11;
      ovfResB.p = 32'h7E007E00; ovfResB.ovf = 2'b11;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstOutValidA", 32'(busA.out_valid), 32'd0);
      checkOutput("rstOutPA", busA.out_p, 32'd0);
      checkOutput("rstOutOvfA", 32'(busA.out_ovf), 32'd0);
      checkOutput("rstOutValidB", 32'(busB.out_valid), 32'd0);
      checkOutput("rstInReadyA", 32'(busA.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Latency from accept to out_valid on an empty pipe
      eA.p = {vecs[1].pA, vecs[0].pA}; eA.ovf = {vecs[1].ovfA, vecs[0].ovfA};
      eB.p = {vecs[1].pB, vecs[0].pB}; eB.ovf = {vecs[1].ovfB, vecs[0].ovfB};
      applyStimulus({vecs[1].a, vecs[0].a}, {vecs[1].b, vecs[0].b}, eA, eB);
      n = 0;
      while (!busA.out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("latency", 32'(n), 32'd3);
      waitDrain();

      // Table vectors streamed back to back
      for (int i = 0; i < 14; i++) begin
         j = (i + 1) % 14;
         eA.p = {vecs[j].pA, vecs[i].pA}; eA.ovf = {vecs[j].ovfA, vecs[i].ovfA};
         eB.p = {vecs[j].pB, vecs[i].pB}; eB.ovf = {vecs[j].ovfB, vecs[i].ovfB};
         applyStimulus({vecs[j].a, vecs[i].a}, {vecs[j].b, vecs[i].b}, eA, eB);
      end
      waitDrain();

      // Backpressure: 8 sets, consumer stalls on cycles 4-6
      sent = 0;
      for (int cyc = 0; cyc < 60 && sent < 8; cyc++) begin
         outReady = !(cyc >= 4 && cyc <= 6);
         if (!inValid) begin
            setOperands($urandom, $urandom & 32'h83FF83FF);
            inValid = 1'b1;
         end
         @(negedge clk);
         if (cyc >= 4 && cyc <= 6) checkOutput("stallInReady", 32'(busA.in_ready), 32'd0);
         if (cyc == 7) checkOutput("resumeInReady", 32'(busA.in_ready), 32'd1);
         acc = busA.in_ready;
         if (acc) sent++;
         @(posedge clk);
         #1;
         if (acc) inValid = 1'b0;
      end
      checkOutput("bpSent", 32'(sent), 32'd8);
      outReady = 1'b1;
      waitDrain();

      // Random traffic with random consumer stalls
      for (int cyc = 0; cyc < 300; cyc++) begin
         outReady = ($urandom_range(0, 3) != 0);
         if (!inValid && $urandom_range(0, 3) != 0) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b = b & 32'h81FF81FF;
            setOperands(a, b);
            inValid = 1'b1;
         end
         @(negedge clk);
         acc = inValid && busA.in_ready;
         @(posedge clk);
         #1;
         if (acc) inValid = 1'b0;
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      waitDrain();

      // Reset with three sets in flight
      outReady = 1'b0;
      for (int k = 0; k < 3; k++) applyStimulus({2{vecs[2].a}}, {2{vecs[2].b}}, ovfResA, ovfResB);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midRstOutValidA", 32'(busA.out_valid), 32'd0);
      checkOutput("midRstOutValidB", 32'(busB.out_valid), 32'd0);
      checkOutput("midRstOutPA", busA.out_p, 32'd0);
      checkOutput("midRstCountA", 32'(ovfCountA), 32'd0);
      checkOutput("midRstCountB", 32'(ovfCountB), 32'd0);
      outReady = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("postRstNoOutA", 32'(busA.out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Counter saturation over 0x10000+ overflowing transfers
      for (int k = 0; k < 65540; k++) applyStimulus({2{vecs[2].a}}, {2{vecs[2].b}}, ovfResA, ovfResB);
      waitDrain();
      checkOutput("ovfCountSatA", 32'(ovfCountA), 32'h0000FFFF);
      checkOutput("ovfCountSatB", 32'(ovfCountB), 32'h0000FFFF);

      // Clear coinciding with an overflowing output transfer
      applyStimulus({2{vecs[2].a}}, {2{vecs[2].b}}, ovfResA, ovfResB);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      ovfClr = 1'b1;
      @(negedge clk);
      checkOutput("clrAlignedValid", 32'(busA.out_valid), 32'd1);
      @(posedge clk);
      #1;
      ovfClr = 1'b0;
      @(negedge clk);
      checkOutput("clrWinsA", 32'(ovfCountA), 32'd0);
      checkOutput("clrWinsB", 32'(ovfCountB), 32'd0);
      waitDrain();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
